// File: rtl/actuation_driver.sv
// actuation_driver: merges redundant unit votes with manual demand, filters, seals in and drives actuators.
//   Macro ACT_FEEDBACK_EN enables actuator position-feedback supervision (fault outputs).
//   Ports:
//     clk         in   system clock, rising edge
//     rst_n       in   asynchronous active-low reset
//     votes_a     in   [NDEV] unit A votes, bit [NDEV-1-d] = device d
//     votes_b     in   [NDEV] unit B votes, same packing as votes_a
//     manual_act  in   [NDEV] manual actuation level, bit [d] = device d
//     reset_req   in   operator actuation reset level, all devices
//     fb_pos      in   [NDEV] in-position feedback, bit [d] = device d (feedback build only)
//     act_out     out  [NDEV] actuator command, registered
//     sealed      out  [NDEV] device in ACT state, registered
//     fault       out  [NDEV] sticky feedback fault, registered (0 without ACT_FEEDBACK_EN)
module actuation_driver #(
    parameter int NDEV       = 2,
    parameter int PERSIST    = 3,
    parameter int FB_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NDEV-1:0] votes_a,
    input  logic [NDEV-1:0] votes_b,
    input  logic [NDEV-1:0] manual_act,
    input  logic            reset_req,
    input  logic [NDEV-1:0] fb_pos,
    output logic [NDEV-1:0] act_out,
    output logic [NDEV-1:0] sealed,
    output logic [NDEV-1:0] fault
);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACT} state_t;
    localparam logic [7:0] P8 = 8'(PERSIST);
`ifdef ACT_FEEDBACK_EN
    localparam logic [15:0] T16 = 16'(FB_TIMEOUT);
`else
    logic w_unused_fb;
    assign w_unused_fb = ^fb_pos;
`endif
    for (genvar d = 0; d < NDEV; d++) begin : g_dev
        state_t     r_state;
        logic [7:0] r_cnt;
        logic       r_act;
        logic       w_auto;
        logic       w_man;
        logic       w_go_act;
        logic       w_release;
        assign w_auto    = votes_a[NDEV-1-d] | votes_b[NDEV-1-d];
        assign w_man     = manual_act[d];
        // r_cnt is always 0 in IDLE, so one compare covers both IDLE (PERSIST==1) and ARM.
        assign w_go_act  = w_man | (w_auto & (r_cnt + 8'd1 == P8));
        assign w_release = reset_req & ~w_auto & ~w_man;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= S_IDLE;
                r_cnt   <= 8'd0;
                r_act   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_ARM: begin
                        r_cnt   <= w_auto ? r_cnt + 8'd1 : 8'd0;
                        r_act   <= w_go_act;
                        r_state <= w_go_act ? S_ACT : (w_auto ? S_ARM : S_IDLE);
                    end
                    S_ACT: begin
                        if (w_release) begin
                            r_state <= S_IDLE;
                            r_cnt   <= 8'd0;
                            r_act   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= 8'd0;
                        r_act   <= 1'b0;
                    end
                endcase
            end
        end
        assign act_out[d] = r_act;
        assign sealed[d]  = r_act;
`ifdef ACT_FEEDBACK_EN
        logic [15:0] r_tmr;
        logic [15:0] r_stk;
        logic        r_frz;
        logic        r_fault;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_tmr   <= 16'd0;
                r_stk   <= 16'd0;
                r_frz   <= 1'b0;
                r_fault <= 1'b0;
            end else begin
                if (r_state != S_ACT && w_go_act) begin
                    r_tmr <= 16'd0;
                    r_frz <= 1'b0;
                end else if (r_state == S_ACT) begin
                    // Once the actuator reports in position the travel timer stops for good.
                    if (fb_pos[d]) begin
                        r_frz <= 1'b1;
                    end else if (!r_frz && r_tmr != T16) begin
                        r_tmr <= r_tmr + 16'd1;
                        if (r_tmr + 16'd1 == T16) r_fault <= 1'b1;
                    end
                end
                // Position reported while idle means a stuck actuator.
                r_stk <= (r_state == S_IDLE && fb_pos[d]) ? (r_stk == T16 ? r_stk : r_stk + 16'd1) : 16'd0;
                if (r_state == S_IDLE && fb_pos[d] && r_stk + 16'd1 == T16) r_fault <= 1'b1;
                if (r_state == S_IDLE && reset_req && !fb_pos[d]) r_fault <= 1'b0;
            end
        end
        assign fault[d] = r_fault;
`else
        assign fault[d] = 1'b0;
`endif
    end
endmodule
